// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: counters, syncs, display enable, strobes and a lead-adjusted fetch request.
// Latency: outputs are registered and match the current counters. ce=0 holds everything. Optional line doubling: VGA_TIMING_DBLSCAN_EN.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int HS_POL     = 0,
  parameter int VS_POL     = 0,
  parameter int FETCH_LEAD = 2,
  parameter int CW         = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  output logic [CW-1:0] h_cnt,
  output logic [CW-1:0] v_cnt,
  output logic          h_sync,
  output logic          v_sync,
  output logic          de,
  output logic          de_n,
  output logic          line_start,
  output logic          frame_start,
  output logic          fetch_req,
  output logic [CW-1:0] fetch_x,
  output logic [CW-1:0] fetch_y
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW:0]   LEAD_W = (CW+1)'(FETCH_LEAD);
  localparam logic [CW:0]   H_TOT_W = (CW+1)'(H_TOTAL);
  localparam logic          HS_ON  = (HS_POL != 0);
  localparam logic          VS_ON  = (VS_POL != 0);

  logic [CW-1:0] h_q, h_d, v_q, v_d, fx_q, fx_d, fy_q, fy_d;
  logic          hs_q, hs_d, vs_q, vs_d, de_q, de_d, dn_q, dn_d;
  logic          ls_q, ls_d, fs_q, fs_d, req_q, req_d;
  logic [CW:0]   t;
  logic [CW-1:0] tx, ty;
  logic          lf;

  always_comb begin
    h_d   = h_q;
    v_d   = v_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    de_d  = de_q;
    dn_d  = dn_q;
    ls_d  = ls_q;
    fs_d  = fs_q;
    req_d = req_q;
    fx_d  = fx_q;
    fy_d  = fy_q;
    t     = '0;
    tx    = '0;
    ty    = '0;
    lf    = 1'b0;
    if (ce) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
      // Outputs decode the next-state counters so they line up with h_cnt/v_cnt.
      hs_d = (h_d >= HS_BEG && h_d < HS_END) ? HS_ON : ~HS_ON;
      vs_d = (v_d >= VS_BEG && v_d < VS_END) ? VS_ON : ~VS_ON;
      de_d = (h_d < H_ACT) && (v_d < V_ACT);
      dn_d = ~de_d;
      ls_d = (h_d == '0);
      fs_d = (h_d == '0) && (v_d == '0);

      t = {1'b0, h_d} + LEAD_W;
      if (t >= H_TOT_W) begin
        tx = CW'(t - H_TOT_W);
        ty = (v_d == V_LAST) ? '0 : v_d + 1'b1;
      end else begin
        tx = CW'(t);
        ty = v_d;
      end
`ifdef VGA_TIMING_DBLSCAN_EN
      lf = (ty < V_ACT) && !ty[0];
`else
      lf = (ty < V_ACT);
`endif
      req_d = (tx < H_ACT) && lf;
      if (req_d) begin
        fx_d = tx;
`ifdef VGA_TIMING_DBLSCAN_EN
        fy_d = {1'b0, ty[CW-1:1]};
`else
        fy_d = ty;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q   <= H_LAST;
      v_q   <= V_LAST;
      hs_q  <= ~HS_ON;
      vs_q  <= ~VS_ON;
      de_q  <= 1'b0;
      dn_q  <= 1'b1;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
      req_q <= 1'b0;
      fx_q  <= '0;
      fy_q  <= '0;
    end else begin
      h_q   <= h_d;
      v_q   <= v_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      de_q  <= de_d;
      dn_q  <= dn_d;
      ls_q  <= ls_d;
      fs_q  <= fs_d;
      req_q <= req_d;
      fx_q  <= fx_d;
      fy_q  <= fy_d;
    end
  end

  assign h_cnt       = h_q;
  assign v_cnt       = v_q;
  assign h_sync      = hs_q;
  assign v_sync      = vs_q;
  assign de          = de_q;
  assign de_n        = dn_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign fetch_req   = req_q;
  assign fetch_x     = fx_q;
  assign fetch_y     = fy_q;

endmodule
